// File: rtl/aes_keymap_var.sv
// Iterative AES-128/192/256 key expander with one shared S-box word lane and an indexed round-key read port.
// Optional build macro AES_KEYMAP_VAR_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_keymap_var #(
    parameter int MAX_NK = 8,
    parameter int RD_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         init,
    input  logic [1:0]   keylen,
    input  logic [255:0] key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [3:0]   round_idx,
    output logic [127:0] round_key,
    output logic [3:0]   num_rounds,
    output logic         ready,
    output logic         error
);
    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r, state_nxt_s;
    logic [31:0]  w_r [DEPTH];
    logic [5:0]   i_r;
    logic [5:0]   last_r;
    logic [2:0]   mod_r;
    logic [3:0]   nk_r;
    logic [7:0]   rcon_r;
    logic [3:0]   nk_s;
    logic [3:0]   nr_s;
    logic         legal_s;
    logic         start_s;
    logic         reject_s;
    logic [31:0]  temp_s;
    logic [31:0]  prev_s;
    logic [31:0]  new_word_s;
    logic [31:0]  sboxw_s;
    logic [5:0]   base_s;
    logic [127:0] rk_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Decode the requested key length.
    always_comb begin
        nk_s    = nk_of(keylen);
        nr_s    = nk_s + 4'd6;
        legal_s = (keylen != 2'd3) && (int'(nk_s) <= MAX_NK);
    end

    // Next state, S-box lane request and next schedule word.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        reject_s    = 1'b0;
        temp_s      = 32'h0;
        prev_s      = 32'h0;
        new_word_s  = 32'h0;
        sboxw_s     = 32'h0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (init) begin
                    if (legal_s) begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_GEN;
                    end else begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_GEN: begin
                temp_s = w_r[i_r - 6'd1];
                prev_s = w_r[i_r - {2'b00, nk_r}];
                if (mod_r == 3'd0) begin
                    sboxw_s    = {temp_s[23:0], temp_s[31:24]};
                    new_word_s = prev_s ^ new_sboxw ^ {rcon_r, 24'h0};
                end else if ((nk_r == 4'd8) && (mod_r == 3'd4)) begin
                    sboxw_s    = temp_s;
                    new_word_s = prev_s ^ new_sboxw;
                end else begin
                    sboxw_s    = temp_s;
                    new_word_s = prev_s ^ temp_s;
                end
                if (i_r == last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_GEN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign sboxw = sboxw_s;

    // Schedule storage, counters and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ready      <= 1'b0;
            error      <= 1'b0;
            num_rounds <= 4'd0;
            i_r        <= 6'd0;
            last_r     <= 6'd0;
            mod_r      <= 3'd0;
            nk_r       <= 4'd0;
            rcon_r     <= 8'h01;
            for (int k = 0; k < DEPTH; k++) begin
                w_r[k] <= 32'h0;
            end
`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
        end else if (zeroize) begin
            state_r    <= ST_IDLE;
            ready      <= 1'b0;
            error      <= 1'b0;
            num_rounds <= 4'd0;
            for (int k = 0; k < DEPTH; k++) begin
                w_r[k] <= 32'h0;
            end
`endif
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                nk_r       <= nk_s;
                num_rounds <= nr_s;
                last_r     <= {nr_s, 2'b11};
                i_r        <= {2'b00, nk_s};
                mod_r      <= 3'd0;
                rcon_r     <= 8'h01;
                ready      <= 1'b0;
                error      <= 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(nk_s)) begin
                        w_r[k] <= key[255 - 32*k -: 32];
                    end
                end
            end else if (reject_s) begin
                error <= 1'b1;
                ready <= 1'b0;
            end else if (state_r == ST_GEN) begin
                w_r[i_r] <= new_word_s;
                i_r      <= i_r + 6'd1;
                // i mod Nk tracked incrementally so no divider is needed
                if ({1'b0, mod_r} == (nk_r - 4'd1)) begin
                    mod_r <= 3'd0;
                end else begin
                    mod_r <= mod_r + 3'd1;
                end
                if (mod_r == 3'd0) begin
                    rcon_r <= xtime(rcon_r);
                end
                if (i_r == last_r) begin
                    ready <= 1'b1;
                end
            end
        end
    end

    // Round-key selection; indices beyond the latched round count read as zero.
    always_comb begin
        base_s = {round_idx, 2'b00};
        rk_s   = 128'h0;
        if (round_idx <= num_rounds) begin
            rk_s = {w_r[base_s], w_r[base_s + 6'd1], w_r[base_s + 6'd2], w_r[base_s + 6'd3]};
        end else begin
            rk_s = 128'h0;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            // Registered read port, one cycle of latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    round_key <= 128'h0;
`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
                end else if (zeroize) begin
                    round_key <= 128'h0;
`endif
                end else begin
                    round_key <= rk_s;
                end
            end
        end else begin : g_rd_comb
            assign round_key = rk_s;
        end
    endgenerate

endmodule

// File: tb/tb_aes_keymap_var.sv
// Self-checking bench for aes_keymap_var: FIPS-197 vector table, randomized keys against a
// behavioural key-schedule model, and hand-written error / restart / reset corner sequences.
module tb_aes_keymap_var;
    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [1:0]   keylen;
    logic [255:0] key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic [3:0]   num_rounds;
    logic         ready;
    logic         error;
`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_w [60];
    int exp_nr;

    aes_keymap_var dut (
        .clk        (clk),
        .reset      (reset),
`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .init       (init),
        .keylen     (keylen),
        .key        (key),
        .sboxw      (sboxw),
        .new_sboxw  (new_sboxw),
        .round_idx  (round_idx),
        .round_key  (round_key),
        .num_rounds (num_rounds),
        .ready      (ready),
        .error      (error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        int e = 254;
        logic [7:0] s;
        while (e > 0) begin
            if (e % 2 == 1) r = gmul(r, p);
            p = gmul(p, p);
            e = e / 2;
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    assign new_sboxw = sub_word(sboxw);

    task automatic model_expand(input logic [1:0] kl, input logic [255:0] k);
        int nk, t;
        logic [31:0] tmp;
        logic [7:0] rc;
        nk = 4 + 2 * int'(kl);
        exp_nr = nk + 6;
        t = 4 * (exp_nr + 1);
        for (int j = 0; j < 60; j++) exp_w[j] = 32'h0;
        for (int j = 0; j < nk; j++) exp_w[j] = k[255 - 32*j -: 32];
        rc = 8'h01;
        for (int j = nk; j < t; j++) begin
            tmp = exp_w[j-1];
            if (j % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && j % nk == 4) begin
                tmp = sub_word(tmp);
            end
            exp_w[j] = exp_w[j-nk] ^ tmp;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One init edge, then scramble key/keylen to prove the latched copies are used.
    task automatic start(input logic [1:0] kl, input logic [255:0] k);
        keylen = kl;
        key = k;
        init = 1'b1;
        tick();
        init = 1'b0;
        keylen = 2'($urandom_range(0, 3));
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_rk(input int idx, output logic [127:0] rk);
        round_idx = 4'(idx);
        tick();
        rk = round_key;
    endtask

    task automatic check_all_rounds(input string tag);
        logic [127:0] rk;
        for (int r = 0; r <= exp_nr; r++) begin
            read_rk(r, rk);
            chk($sformatf("%s_round%0d", tag, r), rk, {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]});
        end
        read_rk(exp_nr + 1, rk);
        chk($sformatf("%s_beyond", tag), rk, 128'h0);
    endtask

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] k;
        int           ridx;
        logic [127:0] exp_rk;
        int           lat;
        logic [3:0]   nr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        logic [127:0] rk;
        logic [255:0] k128, k192, k256;
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        vecs[0] = '{2'd0, 256'h0, 1,  128'h62636363626363636263636362636363, 40, 4'd10};
        vecs[1] = '{2'd0, 256'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 40, 4'd10};
        vecs[2] = '{2'd0, k128,   0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 40, 4'd10};
        vecs[3] = '{2'd0, k128,   10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40, 4'd10};
        vecs[4] = '{2'd1, k192,   12, 128'he98ba06f448c773c8ecc720401002202, 46, 4'd12};
        vecs[5] = '{2'd1, k192,   13, 128'h0,                                46, 4'd12};
        vecs[6] = '{2'd2, k256,   14, 128'hfe4890d1e6188d0b046df344706c631e, 52, 4'd14};

        reset = 1'b1; init = 1'b0; keylen = 2'd0; key = 256'h0; round_idx = 4'd0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_ready", 128'(ready), 128'h0);
        chk("reset_error", 128'(error), 128'h0);
        chk("reset_num_rounds", 128'(num_rounds), 128'h0);
        chk("reset_round_key", round_key, 128'h0);
        chk("reset_sboxw", 128'(sboxw), 128'h0);

        for (int v = 0; v < 7; v++) begin
            start(vecs[v].kl, vecs[v].k);
            wait_ready(n);
            chk($sformatf("vec%0d_latency", v), 128'(n), 128'(vecs[v].lat));
            chk($sformatf("vec%0d_num_rounds", v), 128'(num_rounds), 128'(vecs[v].nr));
            read_rk(vecs[v].ridx, rk);
            chk($sformatf("vec%0d_round_key", v), rk, vecs[v].exp_rk);
        end

        for (int t = 0; t < 5; t++) begin
            logic [1:0] kl;
            logic [255:0] k;
            kl = 2'($urandom_range(0, 2));
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            model_expand(kl, k);
            start(kl, k);
            wait_ready(n);
            chk($sformatf("rand%0d_latency", t), 128'(n), 128'(4 * (exp_nr + 1) - (exp_nr - 6)));
            chk($sformatf("rand%0d_num_rounds", t), 128'(num_rounds), 128'(exp_nr));
            check_all_rounds($sformatf("rand%0d", t));
        end

        // Illegal keylen from DONE: flag error, keep the previous schedule.
        keylen = 2'd3;
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("bad_keylen_error", 128'(error), 128'h1);
        chk("bad_keylen_ready", 128'(ready), 128'h0);
        chk("bad_keylen_num_rounds", 128'(num_rounds), 128'(exp_nr));
        read_rk(1, rk);
        chk("bad_keylen_storage_kept", rk, {exp_w[4], exp_w[5], exp_w[6], exp_w[7]});

        // init pulse mid-generation must be ignored.
        model_expand(2'd0, k128);
        start(2'd0, k128);
        chk("restart_error_cleared", 128'(error), 128'h0);
        n = 0;
        while (!ready && n < 200) begin
            if (n == 4) begin
                init = 1'b1;
                keylen = 2'd1;
            end else begin
                init = 1'b0;
            end
            tick();
            n++;
        end
        init = 1'b0;
        chk("init_in_gen_latency", 128'(n), 128'd40);
        check_all_rounds("init_in_gen");

        // Reset mid-generation clears everything; a fresh run then completes normally.
        start(2'd2, k256);
        for (int c = 0; c < 20; c++) tick();
        round_idx = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_ready", 128'(ready), 128'h0);
        chk("midreset_num_rounds", 128'(num_rounds), 128'h0);
        chk("midreset_round_key", round_key, 128'h0);
        read_rk(0, rk);
        chk("midreset_storage", rk, 128'h0);
        model_expand(2'd2, k256);
        start(2'd2, k256);
        wait_ready(n);
        chk("after_reset_latency", 128'(n), 128'd52);
        check_all_rounds("after_reset");

`ifdef AES_KEYMAP_VAR_ZEROIZE_EN
        zeroize = 1'b1;
        init = 1'b1;
        keylen = 2'd0;
        tick();
        zeroize = 1'b0;
        init = 1'b0;
        chk("zeroize_ready", 128'(ready), 128'h0);
        chk("zeroize_num_rounds", 128'(num_rounds), 128'h0);
        chk("zeroize_round_key", round_key, 128'h0);
        for (int r = 0; r < 16; r++) begin
            read_rk(r, rk);
            chk($sformatf("zeroize_read%0d", r), rk, 128'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
